// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, per-sweep debounce, and a press/release FSM
// that turns single stable key presses into digit writes and '#' check pulses.
module keypad_scanner #(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] keypad_digit,
    output logic       digit_strobe,
    output logic       check_answer
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic {
        HELD  = 1'b0,
        ARMED = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        K_DIGIT,
        K_CLEAR,
        K_CHECK,
        K_IGNORE
    } key_kind_t;

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [15:0]      frame_q, frame_d;
    logic [15:0]      prev_q, prev_d;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    state_t           state_q, state_d;
    logic [3:0]       digit_q, digit_d;
    logic             strobe_q, strobe_d;
    logic             check_n_q, check_n_d;

    logic [3:0]  row_act;
    logic        slot_end;
    logic        sweep_end;
    logic        stable;
    logic        one_hot;
    logic [15:0] frame_new;
    logic [3:0]  key_idx;
    key_kind_t   key_kind;
    logic [3:0]  key_val;

    // NOTE: every _d gets a default before any branch so no latch is inferred.
    always_comb begin
        sync1_d      = rows;
        sync2_d      = sync1_q;
        div_d        = div_q;
        col_d        = col_q;
        frame_d      = frame_q;
        prev_d       = prev_q;
        stable_cnt_d = stable_cnt_q;
        state_d      = state_q;
        digit_d      = digit_q;
        strobe_d     = 1'b0;
        check_n_d    = 1'b1;
        key_idx      = 4'd0;
        key_kind     = K_IGNORE;
        key_val      = 4'd0;

        row_act   = ~sync2_q;
        slot_end  = (div_q == DIV_LAST);
        sweep_end = slot_end && (col_q == 2'd3);

        div_d = slot_end ? '0 : div_q + DIV_W'(1);
        if (slot_end) begin
            col_d = col_q + 2'd1;
        end

        // Current column's rows merged into the frame; at sweep end this is the full frame.
        frame_new = frame_q;
        for (int r = 0; r < 4; r++) begin
            frame_new[4*r + int'(col_q)] = row_act[r];
        end
        if (slot_end) begin
            frame_d = frame_new;
        end

        if (sweep_end) begin
            if (frame_new == prev_q) begin
                if (stable_cnt_q != CNT_MAX) begin
                    stable_cnt_d = stable_cnt_q + CNT_W'(1);
                end
            end else begin
                stable_cnt_d = CNT_W'(1);
                prev_d       = frame_new;
            end
        end

        stable  = sweep_end && (stable_cnt_d == CNT_MAX);
        one_hot = (frame_new != 16'd0) && ((frame_new & (frame_new - 16'd1)) == 16'd0);

        for (int i = 0; i < 16; i++) begin
            if (frame_new[i]) begin
                key_idx = 4'(i);
            end
        end

        case (key_idx)
            4'd0:    begin key_kind = K_DIGIT; key_val = 4'd1; end
            4'd1:    begin key_kind = K_DIGIT; key_val = 4'd2; end
            4'd2:    begin key_kind = K_DIGIT; key_val = 4'd3; end
            4'd4:    begin key_kind = K_DIGIT; key_val = 4'd4; end
            4'd5:    begin key_kind = K_DIGIT; key_val = 4'd5; end
            4'd6:    begin key_kind = K_DIGIT; key_val = 4'd6; end
            4'd8:    begin key_kind = K_DIGIT; key_val = 4'd7; end
            4'd9:    begin key_kind = K_DIGIT; key_val = 4'd8; end
            4'd10:   begin key_kind = K_DIGIT; key_val = 4'd9; end
            4'd12:   key_kind = K_CLEAR;
            4'd13:   begin key_kind = K_DIGIT; key_val = 4'd0; end
            4'd14:   key_kind = K_CHECK;
            default: key_kind = K_IGNORE;
        endcase

        case (state_q)
            HELD: begin
                if (stable && (frame_new == 16'd0)) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (stable && (frame_new != 16'd0)) begin
                    state_d = HELD;
                    if (one_hot) begin
                        case (key_kind)
                            K_DIGIT: begin digit_d = key_val; strobe_d = 1'b1; end
                            K_CLEAR: begin digit_d = 4'd0;    strobe_d = 1'b1; end
                            K_CHECK: check_n_d = 1'b0;
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = HELD;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 4'd0;
            sync2_q      <= 4'd0;
            div_q        <= '0;
            col_q        <= 2'd0;
            frame_q      <= 16'd0;
            prev_q       <= 16'd0;
            stable_cnt_q <= '0;
            state_q      <= HELD;
            digit_q      <= 4'd0;
            strobe_q     <= 1'b0;
            check_n_q    <= 1'b1;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            div_q        <= div_d;
            col_q        <= col_d;
            frame_q      <= frame_d;
            prev_q       <= prev_d;
            stable_cnt_q <= stable_cnt_d;
            state_q      <= state_d;
            digit_q      <= digit_d;
            strobe_q     <= strobe_d;
            check_n_q    <= check_n_d;
        end
    end

    assign cols         = ~(4'b0001 << col_q);
    assign keypad_digit = digit_q;
    assign digit_strobe = strobe_q;
    assign check_answer = check_n_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from cols,
// stimulus queues expected events, and a negedge monitor pops and compares them.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int SWEEP    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  keypad_digit;
    logic        digit_strobe;
    logic        check_answer;
    logic [15:0] pressed;

    typedef struct {
        bit         is_check;
        logic [3:0] digit;
    } evt_t;

    evt_t       sb[$];
    evt_t       mon_e;
    logic [3:0] exp_digit;
    int         checks = 0;
    int         errors = 0;
    int         cyc;
    int         strobe_cnt = 0;
    int         check_cnt = 0;
    int         last_evt_cyc = -1;
    int         s0, c0, press_cyc;

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            rows[r] = ~|(pressed[r*4 +: 4] & ~cols);
        end
    end

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rows        (rows),
        .cols        (cols),
        .keypad_digit(keypad_digit),
        .digit_strobe(digit_strobe),
        .check_answer(check_answer)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("strobe_check_overlap", int'(digit_strobe && !check_answer), 0);
            if (digit_strobe) begin
                strobe_cnt++;
                last_evt_cyc = cyc;
                check("strobe_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("strobe_kind", int'(mon_e.is_check), 0);
                    check("strobe_digit", int'(keypad_digit), int'(mon_e.digit));
                end
            end
            if (!check_answer) begin
                check_cnt++;
                last_evt_cyc = cyc;
                check("check_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("check_kind", int'(mon_e.is_check), 1);
                    check("check_digit", int'(keypad_digit), int'(mon_e.digit));
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align();
        for (int i = 0; i < SWEEP && (cyc % SWEEP) != 0; i++) tick(1);
    endtask

    function automatic logic [15:0] key(int i);
        return 16'(1) << i;
    endfunction

    task automatic expect_digit(logic [3:0] d);
        evt_t e;
        e.is_check = 1'b0;
        e.digit    = d;
        sb.push_back(e);
        exp_digit = d;
    endtask

    task automatic expect_check();
        evt_t e;
        e.is_check = 1'b1;
        e.digit    = exp_digit;
        sb.push_back(e);
    endtask

    task automatic tap(logic [15:0] keys, int hold_sweeps, int rel_sweeps);
        align();
        pressed = keys;
        tick(hold_sweeps * SWEEP);
        pressed = 16'd0;
        tick(rel_sweeps * SWEEP);
    endtask

    task automatic drain(string name);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_cols"}, int'(cols), 4'b1110);
        check({tag, "_digit"}, int'(keypad_digit), 0);
        check({tag, "_strobe"}, int'(digit_strobe), 0);
        check({tag, "_check"}, int'(check_answer), 1);
    endtask

    initial begin
        reset     = 1'b1;
        pressed   = 16'd0;
        exp_digit = 4'd0;
        tick(3);
        check_reset_outputs("rst");
        reset = 1'b0;
        tick(3 * SWEEP);

        // '7' held 10 sweeps: one strobe exactly 3 sweeps after the press
        s0 = strobe_cnt; c0 = check_cnt;
        align();
        expect_digit(4'd7);
        press_cyc = cyc;
        pressed   = key(8);
        tick(10 * SWEEP);
        check("k7_latency", last_evt_cyc - press_cyc, DEB * SWEEP);
        check("k7_strobes", strobe_cnt - s0, 1);
        check("k7_checks", check_cnt - c0, 0);
        check("k7_digit", int'(keypad_digit), 7);
        drain("k7_pending");
        pressed = 16'd0;
        tick(5 * SWEEP);

        // '5' bouncing for 40 cycles, then steady
        s0 = strobe_cnt;
        align();
        expect_digit(4'd5);
        for (int i = 0; i < 8; i++) begin
            pressed[5] = ~pressed[5];
            tick(5);
        end
        pressed = key(5);
        tick(8 * SWEEP);
        check("k5_strobes", strobe_cnt - s0, 1);
        check("k5_digit", int'(keypad_digit), 5);
        drain("k5_pending");
        pressed = 16'd0;
        tick(5 * SWEEP);

        // digit 4, then '#': one-cycle check pulse, digit held
        expect_digit(4'd4);
        tap(key(4), 5, 5);
        check("k4_digit", int'(keypad_digit), 4);
        s0 = strobe_cnt; c0 = check_cnt;
        expect_check();
        tap(key(14), 5, 5);
        check("hash_low_cycles", check_cnt - c0, 1);
        check("hash_strobes", strobe_cnt - s0, 0);
        check("hash_digit", int'(keypad_digit), 4);
        drain("hash_pending");

        // digit 9, then '*' clears, then 'B' ignored
        expect_digit(4'd9);
        tap(key(10), 5, 5);
        check("k9_digit", int'(keypad_digit), 9);
        s0 = strobe_cnt;
        expect_digit(4'd0);
        tap(key(12), 5, 5);
        check("star_strobes", strobe_cnt - s0, 1);
        check("star_digit", int'(keypad_digit), 0);
        s0 = strobe_cnt; c0 = check_cnt;
        tap(key(7), 5, 5);
        check("b_strobes", strobe_cnt - s0, 0);
        check("b_checks", check_cnt - c0, 0);
        check("b_digit", int'(keypad_digit), 0);
        drain("star_b_pending");

        // chord '1'+'2' ignored, then '3'
        s0 = strobe_cnt; c0 = check_cnt;
        tap(key(0) | key(1), 5, 5);
        check("chord_strobes", strobe_cnt - s0, 0);
        check("chord_checks", check_cnt - c0, 0);
        check("chord_digit", int'(keypad_digit), 0);
        expect_digit(4'd3);
        tap(key(2), 5, 5);
        check("k3_digit", int'(keypad_digit), 3);
        drain("k3_pending");

        // '8' held through a mid-sweep reset: no event until a stable release
        align();
        pressed = key(9);
        tick(SWEEP + 5);
        reset     = 1'b1;
        exp_digit = 4'd0;
        tick(3);
        check_reset_outputs("midrst");
        reset = 1'b0;
        s0 = strobe_cnt; c0 = check_cnt;
        tick(6 * SWEEP);
        check("k8_held_strobes", strobe_cnt - s0, 0);
        check("k8_held_checks", check_cnt - c0, 0);
        check("k8_held_digit", int'(keypad_digit), 0);
        pressed = 16'd0;
        tick(DEB * SWEEP);
        expect_digit(4'd8);
        pressed = key(9);
        tick(5 * SWEEP);
        check("k8_digit", int'(keypad_digit), 8);
        check("k8_strobes", strobe_cnt - s0, 1);
        drain("k8_pending");
        pressed = 16'd0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
